// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the 8N1 UART.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int OVERSAMPLE = 8;   // samp_clk strobes per bit
  localparam int DATA_BITS  = 8;
  localparam int MID_SAMPLE = 4;   // samples after start detection to mid start bit

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  // Both machines share state names, so the literals carry a TX_/RX_ prefix
  // to live in one package scope.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser plus 8x-oversampled 8N1 deserialiser.
// Latency: ready/dout registered at the stop-bit mid sample (~9.5 bit times after start edge).
// Backpressure: none; dout is overwritten by the next good byte, ready is a one-clk strobe.
//
// Ports: clk, reset (sync, active-high), samp_clk (sample enable), rin (async serial in),
//        dout (last good byte), ready (new-byte strobe), rx_bit_clk (mid-bit sample strobe).
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       samp_clk,
  input  logic       rin,
  output logic [7:0] dout,
  output logic       ready,
  output logic       rx_bit_clk
);

  logic             rin_meta;
  logic             rin_s;
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BIT_W-1:0] bits, bits_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       dout_n;
  logic             ready_n;
  logic             bitclk_n;
  logic             mid;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rin_meta <= 1'b1;
      rin_s    <= 1'b1;
    end else begin
      rin_meta <= rin;
      rin_s    <= rin_meta;
    end
  end

  // Counter is zeroed on the detecting sample, so the sample that would make it
  // MID_SAMPLE is mid start bit; the 3-bit wrap then lands every 8 samples later.
  assign mid = (cnt == CNT_W'(MID_SAMPLE - 1));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bits_n   = bits;
    shift_n  = shift;
    dout_n   = dout;
    ready_n  = 1'b0;
    bitclk_n = 1'b0;
    if (samp_clk) begin
      if (state == RX_IDLE) begin
        if (!rin_s) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end else begin
        cnt_n = cnt + CNT_W'(1);
        if (mid) begin
          bitclk_n = 1'b1;
          case (state)
            RX_START: begin
              if (rin_s) begin
                state_n = RX_IDLE;           // glitch, not a real start bit
              end else begin
                state_n = RX_DATA;
                bits_n  = '0;
              end
            end
            RX_DATA: begin
              shift_n = {rin_s, shift[7:1]};
              if (bits == BIT_W'(DATA_BITS - 1)) begin
                state_n = RX_STOP;
              end else begin
                bits_n = bits + BIT_W'(1);
              end
            end
            RX_STOP: begin
              // Bad stop bit drops the byte and leaves dout holding the last good one.
              if (rin_s) begin
                dout_n  = shift;
                ready_n = 1'b1;
              end
              state_n = RX_IDLE;
            end
            default: state_n = RX_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bits       <= '0;
      shift      <= '0;
      dout       <= '0;
      ready      <= 1'b0;
      rx_bit_clk <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bits       <= bits_n;
      shift      <= shift_n;
      dout       <= dout_n;
      ready      <= ready_n;
      rx_bit_clk <= bitclk_n;
    end
  end

endmodule

// File: rtl/uart.sv
// 8N1 full-duplex UART: phase-accumulator baud generator, transmitter, and uart_rx.
// Latency: txbusy rises 1 clk after send is accepted; start bit begins at the next tx_bit_clk.
// Backpressure: send is a level request, honoured only while idle or at the end of a stop bit.
//
// Ports: clk, reset (sync, active-high), rin/rout (serial pins), din/send/txbusy (transmit
//        host side), dout/ready (receive host side), samp_clk/rx_bit_clk/tx_bit_clk (debug strobes).
module uart
  import uart_pkg::*;
#(
  parameter int Width = 16,
  parameter int Incr  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rin,
  output logic       rout,
  input  logic [7:0] din,
  input  logic       send,
  output logic       txbusy,
  output logic [7:0] dout,
  output logic       ready,
  output logic       samp_clk,
  output logic       rx_bit_clk,
  output logic       tx_bit_clk
);

  localparam int SumW = Width + 1;

  logic [Width-1:0] acc;
  logic [Width:0]   acc_sum;
  logic [CNT_W-1:0] tx_div;

  tx_state_t        tx_state, tx_state_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic [BIT_W-1:0] tx_bits, tx_bits_n;
  logic             rout_q, rout_n;
  logic             busy_n;

  // Carry out of the accumulator is the sample strobe.
  assign acc_sum = {1'b0, acc} + SumW'(Incr);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      samp_clk   <= 1'b0;
      tx_div     <= '0;
      tx_bit_clk <= 1'b0;
    end else begin
      acc        <= acc_sum[Width-1:0];
      samp_clk   <= acc_sum[Width];
      tx_bit_clk <= samp_clk && (tx_div == '1);
      if (samp_clk) begin
        tx_div <= tx_div + CNT_W'(1);
      end
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_bits_n  = tx_bits;
    rout_n     = rout_q;
    busy_n     = txbusy;
    case (tx_state)
      TX_IDLE: begin
        if (send) begin
          tx_shift_n = din;
          busy_n     = 1'b1;
          tx_state_n = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_bit_clk) begin
          rout_n     = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_clk) begin
          rout_n     = tx_shift[0];
          tx_shift_n = tx_shift >> 1;
          tx_bits_n  = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_clk) begin
          if (tx_bits == BIT_W'(DATA_BITS - 1)) begin
            rout_n     = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            rout_n     = tx_shift[0];
            tx_shift_n = tx_shift >> 1;
            tx_bits_n  = tx_bits + BIT_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_clk) begin
          // A held send chains straight into the next frame so txbusy never drops
          // between back-to-back frames.
          if (send) begin
            tx_shift_n = din;
            tx_state_n = TX_WAIT;
          end else begin
            busy_n     = 1'b0;
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bits  <= '0;
      rout_q   <= 1'b1;
      txbusy   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_bits  <= tx_bits_n;
      rout_q   <= rout_n;
      txbusy   <= busy_n;
    end
  end

  // Force the line idle during reset itself so an aborted frame releases it immediately.
  assign rout = rout_q | reset;

  uart_rx u_rx (
    .clk        (clk),
    .reset      (reset),
    .samp_clk   (samp_clk),
    .rin        (rin),
    .dout       (dout),
    .ready      (ready),
    .rx_bit_clk (rx_bit_clk)
  );

endmodule

// File: tb/tb_uart.sv
// Loopback bench for uart with a byte scoreboard and a serial-line waveform model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart;

  logic       clk = 1'b0;
  logic       reset;
  logic       rin;
  logic       rout;
  logic [7:0] din;
  logic       send;
  logic       txbusy;
  logic [7:0] dout;
  logic       ready;
  logic       samp_clk;
  logic       rx_bit_clk;
  logic       tx_bit_clk;

  logic       force_en;
  logic       force_val;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] sb[$];
  logic [7:0] last_good = 8'h00;

  assign rin = force_en ? force_val : rout;

  uart #(.Width(2), .Incr(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .rin        (rin),
    .rout       (rout),
    .din        (din),
    .send       (send),
    .txbusy     (txbusy),
    .dout       (dout),
    .ready      (ready),
    .samp_clk   (samp_clk),
    .rx_bit_clk (rx_bit_clk),
    .tx_bit_clk (tx_bit_clk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return samp_clk;
      1:       return tx_bit_clk;
      2:       return txbusy;
      3:       return !txbusy;
      default: return !rout;
    endcase
  endfunction

  // Bounded wait; an expired bound counts as a failed check.
  task automatic wait_for(input int sel, input int limit, input string name, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (cond(sel)) begin
        t = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d clks", name, limit);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every ready strobe must match the oldest byte sent over the loop.
  initial begin
    logic [7:0] exp;
    forever begin
      @(posedge clk); #1;
      if (ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", {24'h0, dout}, 32'hFFFF_FFFF);
        end else begin
          exp = sb.pop_front();
          check("rx_byte", {24'h0, dout}, {24'h0, exp});
          last_good = exp;
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit measure, input bit wave);
    int t0, t1, ts;
    logic exp_bit;
    if (txbusy) wait_for(3, 800, "tx_free", t1);
    din  = b;
    send = 1'b1;
    sb.push_back(b);
    wait_for(2, 40, "txbusy_rise", t0);
    send = 1'b0;
    din  = 8'($urandom);
    if (wave) begin
      wait_for(4, 60, "start_bit", ts);
      idle(16);
      for (int i = 0; i < 10; i++) begin
        if (i == 0)      exp_bit = 1'b0;
        else if (i == 9) exp_bit = 1'b1;
        else             exp_bit = 1'((b >> (i - 1)) & 8'h01);
        check($sformatf("wave_bit%0d", i), {31'h0, rout}, {31'h0, exp_bit});
        idle(32);
      end
    end
    wait_for(3, 400, "txbusy_fall", t1);
    if (measure) check_ge("frame_busy_len", t1 - t0, 320);
    idle(8);
    check("rx_drained", sb.size(), 0);
  endtask

  initial begin
    int t_a, t_b, dropped, nstrobe;
    logic [7:0] fe_bits [10];
    reset     = 1'b1;
    send      = 1'b0;
    din       = 8'h00;
    force_en  = 1'b0;
    force_val = 1'b1;

    // Reset state
    idle(8);
    check("rst_rout", {31'h0, rout}, 1);
    check("rst_txbusy", {31'h0, txbusy}, 0);
    check("rst_ready", {31'h0, ready}, 0);
    check("rst_dout", {24'h0, dout}, 0);
    check("rst_strobes", {29'h0, samp_clk, rx_bit_clk, tx_bit_clk}, 0);
    reset = 1'b0;
    idle(64);
    check("idle_txbusy", {31'h0, txbusy}, 0);
    check("idle_rout", {31'h0, rout}, 1);

    // Rates: sample every 4 clks, bit clock every 32
    wait_for(0, 10, "samp", t_a);
    for (int i = 0; i < 3; i++) begin
      wait_for(0, 10, "samp", t_b);
      check("samp_period", t_b - t_a, 4);
      t_a = t_b;
    end
    wait_for(1, 40, "txbit", t_a);
    for (int i = 0; i < 2; i++) begin
      wait_for(1, 40, "txbit", t_b);
      check("txbit_period", t_b - t_a, 32);
      t_a = t_b;
    end

    // Loopback traffic
    send_frame(8'hA9, 1'b1, 1'b0);
    send_frame(8'hA9, 1'b0, 1'b1);
    send_frame(8'h99, 1'b1, 1'b0);
    idle(500);
    send_frame(8'hB1, 1'b0, 1'b0);
    send_frame(8'hEA, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b0, 1'b0);

    // Send held high: two chained frames
    din  = 8'h55;
    send = 1'b1;
    sb.push_back(8'h55);
    sb.push_back(8'h55);
    wait_for(2, 40, "b2b_rise", t_a);
    dropped = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!txbusy) dropped = 1;
    end
    send = 1'b0;
    check("b2b_busy_held", dropped, 0);
    wait_for(3, 700, "b2b_fall", t_b);
    check_ge("b2b_busy_len", t_b - t_a, 640);
    idle(100);
    check("b2b_rx_count", sb.size(), 0);
    check("b2b_no_third", {31'h0, txbusy}, 0);

    // One-sample low glitch: false start
    force_en  = 1'b1;
    force_val = 1'b0;
    idle(4);
    force_val = 1'b1;
    nstrobe   = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rx_bit_clk) nstrobe++;
    end
    check("false_start_strobes", nstrobe, 1);
    check("false_start_dout", {24'h0, dout}, {24'h0, last_good});

    // Frame with a 0 stop bit: framing error
    fe_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) fe_bits[i + 1] = 1'((8'h3C >> i) & 8'h01);
    fe_bits[9] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      force_val = fe_bits[i];
      idle(32);
    end
    force_val = 1'b1;
    idle(200);
    force_en = 1'b0;
    check("frame_err_dout", {24'h0, dout}, {24'h0, last_good});
    check("frame_err_queue", sb.size(), 0);

    // Reset in the middle of a frame of zeros
    din  = 8'h00;
    send = 1'b1;
    wait_for(2, 40, "mid_rst_rise", t_a);
    send = 1'b0;
    wait_for(4, 60, "mid_rst_start", t_a);
    idle(100);
    check("mid_frame_rout_low", {31'h0, rout}, 0);
    reset = 1'b1;
    #2;
    check("rst_rout_same_clk", {31'h0, rout}, 1);
    idle(2);
    check("mid_rst_txbusy", {31'h0, txbusy}, 0);
    check("mid_rst_dout", {24'h0, dout}, 0);
    reset     = 1'b0;
    last_good = 8'h00;
    idle(400);
    check("post_rst_idle", {31'h0, txbusy}, 0);
    send_frame(8'($urandom), 1'b1, 1'b0);

    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- 8N1 full-duplex UART with a phase-accumulator baud generator and 8x receive oversampling.
- The transmitter serialises a byte on rout when send is asserted. The receiver deserialises rin and strobes ready per valid byte.
- Internal timing strobes are exported for debug and test. Sits between a byte-wide host interface and a serial pin pair; rout may loop back to rin.

Parameters:
- Width, 16, bit width of the baud phase accumulator.
- Incr, 1, accumulator increment per clk. Sample rate = f_clk*Incr/2^Width; baud = sample rate/8.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rin  in  1  serial receive line, idle high, asynchronous
- rout  out  1  serial transmit line, idle high
- din  in  8  transmit byte, sampled only at transmit acceptance
- send  in  1  level request to transmit din
- txbusy  out  1  high while a frame is in progress
- dout  out  8  last received byte, held until the next good byte
- ready  out  1  one-clk strobe: dout has a new byte
- samp_clk  out  1  one-clk sample strobe (accumulator carry)
- rx_bit_clk  out  1  one-clk strobe at each receiver mid-bit sample
- tx_bit_clk  out  1  one-clk strobe at each transmit bit boundary

Behaviour:
- Reset (synchronous):
  - accumulator, dividers and state machines cleared
  - rout=1, txbusy=0, ready=0, dout=0, all strobes 0
- Baud generator:
  - acc (Width bits) <= acc+Incr every clk.
  - samp_clk=1 in the clk where the addition carries out of bit Width-1.
  - Width=2, Incr=1 gives samp_clk every 4 clks.
- tx_bit_clk:
  - free-running 3-bit counter of samp_clk strobes
  - strobes when the counter wraps, i.e. every 8th samp_clk
- TX FSM states: IDLE, WAIT, START, DATA, STOP.
  - IDLE & send=1: latch din, txbusy<=1 next clk, go to WAIT. din may change freely afterwards.
  - WAIT: at the next tx_bit_clk, rout<=0 (START).
  - START, DATA: each following tx_bit_clk shifts out data bit 0..7 (LSB first), then rout<=1 (STOP).
  - STOP: at the tx_bit_clk ending the stop bit, txbusy<=0 and go to IDLE.
  - If send is still high in IDLE, a new frame begins immediately (send is level, not edge).
- RX input: rin passes through a 2-flop synchroniser, initialised to 1 on reset. The receiver acts only on samp_clk.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: synchronised rin=0 on a samp_clk → START, phase counter=0.
  - Mid-bit sampling: every 8 samp_clks thereafter, first at count 4 (mid start bit). rx_bit_clk strobes on each mid-bit sample.
  - START mid-bit: rin=1 is a false start → IDLE, no output. Otherwise → DATA.
  - DATA: 8 samples shifted LSB first → STOP.
  - STOP mid-bit, rin=1: dout<=byte and ready=1 for exactly one clk, in the same clk. dout is valid when ready rises.
  - STOP mid-bit, rin=0: framing error; byte discarded, no ready, dout unchanged.
  - Either outcome → IDLE. A new start can be detected from the next samp_clk.
- TX and RX are independent; simultaneous transmit and receive are supported.
- Reset mid-frame: abort both FSMs; rout returns high in the same clk as reset.

Decomposition:
- Package uart_pkg holds:
  - OVERSAMPLE=8, DATA_BITS=8, MID_SAMPLE=4
  - enum tx_state_t {IDLE,WAIT,START,DATA,STOP}
  - enum rx_state_t {IDLE,START,DATA,STOP}
- One sub-module, uart_rx: synchroniser plus RX FSM, driven by clk/reset/samp_clk.
- Baud generator and TX stay in uart.

Test Plan (Width=2, Incr=1, rout looped to rin):
- Reset held 8 clks, then 2 tx_bit_clk periods → txbusy=0, ready=0, rout=1.
- Rates → samp_clk strobes every 4 clks; tx_bit_clk every 32 clks; a full frame holds txbusy high for ≥320 clks.
- Loopback: send 0xA9, drop send on txbusy rise → ready strobes once with dout=0xA9. Then 0x99, an idle gap of ~500 clks, 0xB1 and 0xEA each return correctly.
- Waveform: send 0xA9 → rout shows 0,1,0,0,1,0,1,0,1,1, each bit 32 clks.
- Send held high with din=0x55 → back-to-back frames; txbusy stays high across the boundary; ready strobes once per frame.
- Drive rin low for 1 sample only → false start, no ready. Frame with stop bit 0 → no ready, dout unchanged.
